// File: rtl/iq_upconverter_pkg.sv
// Shared constants and elaboration helpers for the I/Q upconverter.
//   SAMPLE_W    : I/Q sample and table entry width
//   LUT_AMPL    : peak amplitude of the sine table
//   DAC_MID     : offset-binary midscale code
//   ROUND_SHIFT : right shift that rescales the mixer product back to 8 bits
//   PIPE_LAT    : clock edges from input sampling to dac_out
package iq_upconverter_pkg;

  localparam int SAMPLE_W    = 8;
  localparam int LUT_AMPL    = 127;
  localparam logic [7:0] DAC_MID = 8'h80;
  localparam int ROUND_SHIFT = 7;
  localparam int PIPE_LAT    = 4;
  localparam int PROD_W      = 2 * SAMPLE_W;
  localparam int DIFF_W      = PROD_W + 1;

  localparam logic signed [DIFF_W-1:0] ROUND_BIAS = 17'sd64;
  localparam logic signed [DIFF_W-1:0] SAT_MAX    = 17'sd127;
  localparam logic signed [DIFF_W-1:0] SAT_MIN    = -17'sd128;

  // round(LUT_AMPL * sin(2*pi*n / 2^aw)), halves rounded away from zero
  function automatic logic signed [SAMPLE_W-1:0] sine_entry(input int n, input int aw);
    real x;
    real r;
    x = real'(LUT_AMPL) * $sin(2.0 * 3.14159265358979323846 * real'(n) / real'(1 << aw));
    if (x >= 0.0) begin
      r = $floor(x + 0.5);
    end else begin
      r = $ceil(x - 0.5);
    end
    return SAMPLE_W'($rtoi(r));
  endfunction

  // Clamp a rescaled mixer value to the signed 8-bit range
  function automatic logic signed [SAMPLE_W-1:0] saturate(input logic signed [DIFF_W-1:0] v);
    logic signed [SAMPLE_W-1:0] res;
    if (v > SAT_MAX) begin
      res = 8'sd127;
    end else if (v < SAT_MIN) begin
      res = -8'sd128;
    end else begin
      res = v[SAMPLE_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/iq_upconverter_if.sv
// Sample/DAC bundle of the upconverter.
//   enable, phase_inc, sample_i, sample_q : driven by the sampler side (master)
//   dac_out, dac_valid                    : driven by the upconverter (slave)
interface iq_upconverter_if
  import iq_upconverter_pkg::*;
#(
  parameter int PHASE_W = 24
);

  logic                       enable;
  logic [PHASE_W-1:0]         phase_inc;
  logic signed [SAMPLE_W-1:0] sample_i;
  logic signed [SAMPLE_W-1:0] sample_q;
  logic [SAMPLE_W-1:0]        dac_out;
  logic                       dac_valid;

  modport master (
    output enable, phase_inc, sample_i, sample_q,
    input  dac_out, dac_valid
  );

  modport slave (
    input  enable, phase_inc, sample_i, sample_q,
    output dac_out, dac_valid
  );

endinterface

// File: rtl/iq_upconverter_nco_sine_rom.sv
// Dual-read sine table forming the table half of the first pipeline stage.
//   clk, rst         : clock, synchronous active-high reset (outputs clear to 0)
//   sin_idx, cos_idx : table addresses
//   sin_val, cos_val : registered signed table entries
module nco_sine_rom
  import iq_upconverter_pkg::*;
#(
  parameter int LUT_AW = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LUT_AW-1:0]          sin_idx,
  input  logic [LUT_AW-1:0]          cos_idx,
  output logic signed [SAMPLE_W-1:0] sin_val,
  output logic signed [SAMPLE_W-1:0] cos_val
);

  localparam int DEPTH = 1 << LUT_AW;

  logic signed [SAMPLE_W-1:0] table_s [DEPTH];

  // Table contents are constant expressions of the entry index
  for (genvar n = 0; n < DEPTH; n++) begin : g_tab
    assign table_s[n] = sine_entry(n, LUT_AW);
  end

  // Registered read of both ports
  always_ff @(posedge clk) begin
    if (rst) begin
      sin_val <= '0;
      cos_val <= '0;
    end else begin
      sin_val <= table_s[sin_idx];
      cos_val <= table_s[cos_idx];
    end
  end

endmodule

// File: rtl/iq_upconverter.sv
// Quadrature upconverter: out = I*cos(phase) - Q*sin(phase), NCO-driven carrier,
// four-stage pipeline, rounded and saturated, offset-binary DAC output.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of iq_upconverter_if (enable, phase_inc, sample_i,
//              sample_q in; dac_out, dac_valid out)
module iq_upconverter
  import iq_upconverter_pkg::*;
#(
  parameter int PHASE_W = 24,
  parameter int LUT_AW  = 8
) (
  input  logic            clk,
  input  logic            rst,
  iq_upconverter_if.slave bus
);

  localparam logic [LUT_AW-1:0] QUARTER = LUT_AW'(1 << (LUT_AW - 2));

  logic [PHASE_W-1:0]         phase_r;
  logic [LUT_AW-1:0]          sin_idx_s;
  logic [LUT_AW-1:0]          cos_idx_s;
  logic signed [SAMPLE_W-1:0] sin1_s;
  logic signed [SAMPLE_W-1:0] cos1_s;
  logic signed [SAMPLE_W-1:0] i1_r;
  logic signed [SAMPLE_W-1:0] q1_r;
  logic signed [PROD_W-1:0]   p_i2_r;
  logic signed [PROD_W-1:0]   p_q2_r;
  logic signed [DIFF_W-1:0]   d3_r;
  logic [PIPE_LAT-2:0]        valid_pipe_r;   // bit 0 = stage 1 ... top bit = stage 3
  logic signed [DIFF_W-1:0]   scaled_s;
  logic signed [SAMPLE_W-1:0] sat_s;
  logic [SAMPLE_W-1:0]        dac_next_s;
  logic [SAMPLE_W-1:0]        dac_out_r;
  logic                       dac_valid_r;

  assign sin_idx_s = phase_r[PHASE_W-1 -: LUT_AW];
  assign cos_idx_s = sin_idx_s + QUARTER;   // cos leads sin by a quarter turn, wraps mod table size

  // Phase accumulator: wraps silently, frozen while disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r <= '0;
    end else if (bus.enable) begin
      phase_r <= phase_r + bus.phase_inc;
    end else begin
      phase_r <= phase_r;
    end
  end

  nco_sine_rom #(
    .LUT_AW (LUT_AW)
  ) u_rom (
    .clk     (clk),
    .rst     (rst),
    .sin_idx (sin_idx_s),
    .cos_idx (cos_idx_s),
    .sin_val (sin1_s),
    .cos_val (cos1_s)
  );

  // Stages 1-3: sample capture, products, difference, valid shift
  always_ff @(posedge clk) begin
    if (rst) begin
      i1_r         <= '0;
      q1_r         <= '0;
      p_i2_r       <= '0;
      p_q2_r       <= '0;
      d3_r         <= '0;
      valid_pipe_r <= '0;
    end else begin
      i1_r         <= bus.sample_i;
      q1_r         <= bus.sample_q;
      p_i2_r       <= PROD_W'(i1_r) * PROD_W'(cos1_s);
      p_q2_r       <= PROD_W'(q1_r) * PROD_W'(sin1_s);
      d3_r         <= DIFF_W'(p_i2_r) - DIFF_W'(p_q2_r);
      valid_pipe_r <= {valid_pipe_r[PIPE_LAT-3:0], bus.enable};
    end
  end

  // Stage 4 datapath: round to nearest, saturate, convert to offset binary
  always_comb begin
    scaled_s = (d3_r + ROUND_BIAS) >>> ROUND_SHIFT;
    sat_s    = saturate(scaled_s);
    if (valid_pipe_r[PIPE_LAT-2]) begin
      dac_next_s = sat_s ^ DAC_MID;
    end else begin
      dac_next_s = DAC_MID;
    end
  end

  // Stage 4 output register
  always_ff @(posedge clk) begin
    if (rst) begin
      dac_out_r   <= DAC_MID;
      dac_valid_r <= 1'b0;
    end else begin
      dac_out_r   <= dac_next_s;
      dac_valid_r <= valid_pipe_r[PIPE_LAT-2];
    end
  end

  assign bus.dac_out   = dac_out_r;
  assign bus.dac_valid = dac_valid_r;

endmodule

// File: tb/tb_iq_upconverter.sv
// Self-checking bench for iq_upconverter: a reference model predicts each
// cycle's output, queues it, and compares it against the DUT four edges later;
// scenario tasks add hand-derived constant checks.
module tb_iq_upconverter;

  logic clk;
  logic rst;

  iq_upconverter_if #(.PHASE_W(24)) bus ();

  iq_upconverter #(.PHASE_W(24), .LUT_AW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [7:0] out;
  } exp_t;

  exp_t       sb[$];
  logic [23:0] model_phase;
  logic [7:0] last_out;
  logic       last_valid;
  int         checks;
  int         errors;

  // round(127*sin(2*pi*n/256)), halves away from zero
  function automatic int tab(input int n);
    real x;
    x = 127.0 * $sin(2.0 * 3.14159265358979323846 * real'(n) / 256.0);
    if (x >= 0.0) return $rtoi($floor(x + 0.5));
    else return $rtoi($ceil(x - 0.5));
  endfunction

  function automatic logic [7:0] model_out(input logic [23:0] ph,
                                           input logic signed [7:0] si,
                                           input logic signed [7:0] sq);
    int idx, s, c, d, r;
    logic [7:0] rb;
    idx = int'(ph[23:16]);
    s   = tab(idx);
    c   = tab((idx + 64) % 256);
    d   = int'(si) * c - int'(sq) * s;
    r   = (d + 64) >>> 7;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    rb = 8'(r);
    return rb ^ 8'h80;
  endfunction

  // One clock edge: predict, advance, compare against the scoreboard
  task automatic step();
    exp_t e;
    if (rst) begin
      @(posedge clk);
      #1;
      model_phase = 24'h0;
      sb.delete();
      checks++;
      if (bus.dac_out !== 8'h80 || bus.dac_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_out t=%0t got %h/%b want 80/0", $time, bus.dac_out, bus.dac_valid);
      end
      checks++;
      if (dut.phase_r !== 24'h0) begin
        errors++;
        $display("FAIL reset_phase t=%0t got %h want 000000", $time, dut.phase_r);
      end
      repeat (3) sb.push_back('{valid: 1'b0, out: 8'h80});
    end else begin
      e.valid = bus.enable;
      e.out   = bus.enable ? model_out(model_phase, bus.sample_i, bus.sample_q) : 8'h80;
      sb.push_back(e);
      if (bus.enable) model_phase = model_phase + bus.phase_inc;
      @(posedge clk);
      #1;
      if (sb.size() >= 4) begin
        e = sb.pop_front();
        checks++;
        if (bus.dac_out !== e.out || bus.dac_valid !== e.valid) begin
          errors++;
          $display("FAIL scoreboard t=%0t got %h/%b want %h/%b", $time,
                   bus.dac_out, bus.dac_valid, e.out, e.valid);
        end
      end
    end
    last_out   = bus.dac_out;
    last_valid = bus.dac_valid;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.enable    = 1'b1;
    bus.phase_inc = 24'($urandom);
    bus.sample_i  = 8'($urandom);
    bus.sample_q  = 8'($urandom);
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (last_valid !== (k == 4)) begin
        errors++;
        $display("FAIL reset_release_valid edge %0d got %b want %b", k, last_valid, (k == 4));
      end
    end
  endtask

  task automatic test_dc();
    bus.enable = 1'b1; bus.phase_inc = 24'h0;
    bus.sample_i = 8'sd100; bus.sample_q = 8'sd0;
    do_reset();
    repeat (6) step();
    checks++;
    if (last_out !== 8'hE3) begin
      errors++; $display("FAIL dc_steady got %h want e3", last_out);
    end
    bus.sample_i = 8'sd0;
    repeat (3) step();
    checks++;
    if (last_out !== 8'hE3) begin
      errors++; $display("FAIL dc_latency_early got %h want e3", last_out);
    end
    step();
    checks++;
    if (last_out !== 8'h80) begin
      errors++; $display("FAIL dc_latency got %h want 80", last_out);
    end
  endtask

  task automatic test_quarter_and_enable();
    logic [7:0]  seq [4];
    logic [23:0] frozen;
    seq = '{8'hE3, 8'h80, 8'h1D, 8'h80};
    bus.enable = 1'b1; bus.phase_inc = 24'h400000;
    bus.sample_i = 8'sd100; bus.sample_q = 8'sd0;
    do_reset();
    repeat (3) step();
    for (int j = 0; j < 8; j++) begin
      step();
      checks++;
      if (last_out !== seq[j % 4]) begin
        errors++; $display("FAIL quarter[%0d] got %h want %h", j, last_out, seq[j % 4]);
      end
    end
    // drop enable mid-stream
    frozen = model_phase;
    bus.enable = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (last_valid !== (k <= 3)) begin
        errors++; $display("FAIL drain_valid edge %0d got %b want %b", k, last_valid, (k <= 3));
      end
    end
    checks++;
    if (last_out !== 8'h80 || dut.phase_r !== frozen) begin
      errors++; $display("FAIL disabled_hold got %h ph %h want 80 ph %h", last_out, dut.phase_r, frozen);
    end
    // re-enable, then a single-cycle reset mid-stream
    bus.enable = 1'b1;
    repeat (2) step();
    do_reset();
    repeat (3) step();
    step();
    checks++;
    if (last_out !== 8'hE3 || last_valid !== 1'b1) begin
      errors++; $display("FAIL restart_phase0 got %h/%b want e3/1", last_out, last_valid);
    end
  endtask

  task automatic test_saturation();
    bus.enable = 1'b1; bus.phase_inc = 24'h200000;
    bus.sample_i = -8'sd128; bus.sample_q = 8'sd127;
    do_reset();
    repeat (3) step();
    step();
    checks++;
    if (last_out !== 8'h01) begin
      errors++; $display("FAIL sat_idx0 got %h want 01", last_out);
    end
    step();
    checks++;
    if (last_out !== 8'h00) begin
      errors++; $display("FAIL sat_idx32 got %h want 00", last_out);
    end
    repeat (14) step();
  endtask

  task automatic test_wrap();
    bus.enable = 1'b1; bus.phase_inc = 24'hFFFFFF;
    bus.sample_i = 8'sd0; bus.sample_q = 8'sd100;
    do_reset();
    repeat (3) step();
    step();
    checks++;
    if (last_out !== 8'h80) begin
      errors++; $display("FAIL wrap_idx0 got %h want 80", last_out);
    end
    step();
    checks++;
    if (last_out !== 8'h82) begin
      errors++; $display("FAIL wrap_idx255 got %h want 82", last_out);
    end
    repeat (260) step();
    // 4 * 0xC00000 = 2^24 + 2^25: accumulator must land back on 0
    bus.phase_inc = 24'hC00000;
    do_reset();
    repeat (4) step();
    checks++;
    if (dut.phase_r !== 24'h0) begin
      errors++; $display("FAIL phase_wrap got %h want 000000", dut.phase_r);
    end
    repeat (4) step();
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 400; n++) begin
      bus.enable    = ($urandom_range(0, 7) != 0);
      bus.phase_inc = 24'($urandom);
      bus.sample_i  = 8'($urandom);
      bus.sample_q  = 8'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step();
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    model_phase = 24'h0;
    bus.enable = 1'b0;
    bus.phase_inc = 24'h0;
    bus.sample_i = 8'sd0;
    bus.sample_q = 8'sd0;
    test_reset();
    test_dc();
    test_quarter_and_enable();
    test_saturation();
    test_wrap();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
